// File: rtl/up_counter_pkg.sv
// Shared definitions for the up-counter controller: FSM state encoding and
// the prescaler counter width.
package up_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Wide enough for the largest legal PRESC value (255).
   localparam int PRESC_W = 8;

endpackage

// File: rtl/up_counter_ctrl_tick_gen.sv
// Prescaler: while enabled, raises tick once every PRESC cycles; a synchronous
// clear restarts the division phase.
module tick_gen
   import up_counter_pkg::*;
#(
   parameter int PRESC = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam logic [PRESC_W-1:0] LAST_CNT = PRESC_W'(PRESC - 1);

   logic [PRESC_W-1:0] cnt_q;
   logic [PRESC_W-1:0] cnt_d;

   assign tick_o = en_i & (cnt_q == LAST_CNT);

   // clear wins over enable so a restart always begins a full PRESC period
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (tick_o) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + PRESC_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/up_counter_ctrl.sv
// Up counter with IDLE/RUN/DONE control, prescaled counting, one-shot or
// free-running wrap, and saturating synchronous load.
module up_counter_ctrl
   import up_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int PRESC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] counter,
   output logic             tc,
   output logic             wrap,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] counter_q;
   logic [WIDTH-1:0] counter_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             busy_q;
   logic             busy_d;
   logic             done_q;
   logic             done_d;

   logic             run_s;
   logic             tick_s;
   logic             presc_clr_s;
   logic             at_term_s;
   logic [WIDTH-1:0] load_sat_s;

   assign run_s      = (state_q == ST_RUN);
   assign at_term_s  = (counter_q >= max_val);
   assign load_sat_s = (load_val > max_val) ? max_val : load_val;

   tick_gen #(
      .PRESC (PRESC)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .en_i   (run_s),
      .clr_i  (presc_clr_s),
      .tick_o (tick_s)
   );

   // Load overrides count, start and tick, but a simultaneous stop still
   // drops a running counter back to IDLE.
   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      wrap_d      = 1'b0;
      presc_clr_s = 1'b0;
      if (load) begin
         counter_d   = load_sat_s;
         presc_clr_s = 1'b1;
         if ((state_q == ST_RUN) && !stop) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (stop) begin
         presc_clr_s = 1'b1;
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d     = ST_RUN;
                  presc_clr_s = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (tick_s) begin
                  if (!at_term_s) begin
                     counter_d = counter_q + WIDTH'(1);
                  end else if (oneshot) begin
                     counter_d = max_val;
                     state_d   = ST_DONE;
                  end else begin
                     counter_d = '0;
                     wrap_d    = 1'b1;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_d     = ST_RUN;
                  counter_d   = '0;
                  presc_clr_s = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Status flags follow the state being entered so they align with it.
   always_comb begin
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         counter_q <= '0;
         wrap_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         wrap_q    <= wrap_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign counter = counter_q;
   assign tc      = at_term_s;
   assign wrap    = wrap_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Two instances (PRESC=1 and PRESC=3) share stimulus and are compared each
// cycle against a behavioural model, with directed scenarios then random traffic.
module tb_up_counter_ctrl;

   localparam int W      = 4;
   localparam int IDLE_M = 0;
   localparam int RUN_M  = 1;
   localparam int DONE_M = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         stop;
   logic         oneshot;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] max_val;

   logic [W-1:0] cnt1, cnt3;
   logic         tc1, wrap1, busy1, done1;
   logic         tc3, wrap3, busy3, done3;

   always #5 clk = ~clk;

   up_counter_ctrl #(.WIDTH(W), .PRESC(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot),
      .load(load), .load_val(load_val), .max_val(max_val),
      .counter(cnt1), .tc(tc1), .wrap(wrap1), .busy(busy1), .done(done1)
   );

   up_counter_ctrl #(.WIDTH(W), .PRESC(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot),
      .load(load), .load_val(load_val), .max_val(max_val),
      .counter(cnt3), .tc(tc3), .wrap(wrap3), .busy(busy3), .done(done3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int presc_of [2] = '{1, 3};
   int m_mode   [2];
   int m_cnt    [2];
   int m_runs   [2];
   int m_wrap   [2];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = IDLE_M;
         m_cnt[k]  = 0;
         m_runs[k] = 0;
         m_wrap[k] = 0;
      end
   endtask

   // One clock of the reference behaviour, evaluated from the sampled inputs.
   task automatic model_step(input int k);
      int mx = int'(max_val);
      int nm = m_mode[k];
      int nc = m_cnt[k];
      int w  = 0;
      if (load) begin
         nc = (int'(load_val) > mx) ? mx : int'(load_val);
         m_runs[k] = 0;
         nm = (m_mode[k] == RUN_M && !stop) ? RUN_M : IDLE_M;
      end else if (stop) begin
         m_runs[k] = 0;
         nm = IDLE_M;
      end else if (start && m_mode[k] != RUN_M) begin
         if (m_mode[k] == DONE_M) nc = 0;
         nm = RUN_M;
         m_runs[k] = 0;
      end else if (m_mode[k] == RUN_M) begin
         m_runs[k]++;
         if (m_runs[k] % presc_of[k] == 0) begin
            if (m_cnt[k] >= mx) begin
               if (oneshot) begin
                  nc = mx;
                  nm = DONE_M;
               end else begin
                  nc = 0;
                  w  = 1;
               end
            end else begin
               nc = (m_cnt[k] + 1) % (1 << W);
            end
         end
      end
      m_mode[k] = nm;
      m_cnt[k]  = nc;
      m_wrap[k] = w;
   endtask

   task automatic check_all();
      check_eq("cnt1",  cnt1,  m_cnt[0]);
      check_eq("tc1",   tc1,   (m_cnt[0] >= int'(max_val)) ? 1 : 0);
      check_eq("wrap1", wrap1, m_wrap[0]);
      check_eq("busy1", busy1, (m_mode[0] == RUN_M) ? 1 : 0);
      check_eq("done1", done1, (m_mode[0] == DONE_M) ? 1 : 0);
      check_eq("cnt3",  cnt3,  m_cnt[1]);
      check_eq("tc3",   tc3,   (m_cnt[1] >= int'(max_val)) ? 1 : 0);
      check_eq("wrap3", wrap3, m_wrap[1]);
      check_eq("busy3", busy3, (m_mode[1] == RUN_M) ? 1 : 0);
      check_eq("done3", done3, (m_mode[1] == DONE_M) ? 1 : 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all();
   endtask

   task automatic do_load(input int v);
      load_val = W'(v);
      load = 1'b1;
      cycle();
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   initial begin
      int prev;
      reset = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; load = 1'b0;
      load_val = '0; max_val = W'(9);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      cycle();

      // free-run 0..9 with wrap pulses
      pulse_start();
      for (int i = 0; i < 25; i++) begin
         prev = int'(cnt1);
         cycle();
         if (prev == 9) begin
            check_eq("wrap_after_9", wrap1, 1);
            check_eq("zero_after_9", cnt1, 0);
         end
      end
      stop = 1'b1; cycle(); stop = 1'b0;

      // one-shot to 5, then restart from 0
      oneshot = 1'b1; max_val = W'(5);
      do_load(0);
      pulse_start();
      repeat (12) cycle();
      check_eq("os_hold", cnt1, 5);
      check_eq("os_done", done1, 1);
      check_eq("os_busy", busy1, 0);
      pulse_start();
      check_eq("os_restart", cnt1, 0);
      check_eq("os_rebusy", busy1, 1);
      stop = 1'b1; cycle(); stop = 1'b0;

      // prescaled count, stop at 7, resume at 8
      oneshot = 1'b0; max_val = W'(15);
      do_load(0);
      pulse_start();
      for (int i = 0; i < 60 && cnt3 !== W'(7); i++) cycle();
      check_eq("reach7", cnt3, 7);
      stop = 1'b1; cycle(); stop = 1'b0;
      check_eq("p3_stop_busy", busy3, 0);
      repeat (4) cycle();
      check_eq("p3_hold7", cnt3, 7);
      pulse_start();
      repeat (3) cycle();
      check_eq("p3_resume8", cnt3, 8);

      // saturating load during RUN, then load+stop
      max_val = W'(10);
      do_load(12);
      check_eq("ld_sat", cnt1, 10);
      check_eq("ld_tc", tc1, 1);
      check_eq("ld_busy", busy1, 1);
      load = 1'b1; stop = 1'b1; cycle(); load = 1'b0; stop = 1'b0;
      check_eq("ldstop_cnt", cnt1, 10);
      check_eq("ldstop_idle", busy1, 0);

      // asynchronous reset mid-RUN
      max_val = W'(9);
      do_load(0);
      pulse_start();
      for (int i = 0; i < 20 && cnt1 !== W'(6); i++) cycle();
      check_eq("reach6", cnt1, 6);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_cnt1", cnt1, 0);
      check_eq("arst_busy1", busy1, 0);
      check_eq("arst_cnt3", cnt3, 0);
      model_reset();
      check_all();
      #1;
      reset = 1'b0;
      repeat (5) cycle();
      check_eq("arst_nocount", cnt1, 0);

      // max_val = 0 wraps every tick; lowering max_val mid-RUN
      max_val = '0;
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         cycle();
         check_eq("m0_wrap", wrap1, 1);
         check_eq("m0_cnt", cnt1, 0);
      end
      max_val = W'(12);
      do_load(8);
      check_eq("low_pre", cnt1, 8);
      max_val = W'(4);
      cycle();
      check_eq("low_cnt", cnt1, 0);
      check_eq("low_wrap", wrap1, 1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         start    = ($urandom % 8) == 0;
         stop     = ($urandom % 16) == 0;
         load     = ($urandom % 20) == 0;
         load_val = W'($urandom);
         if (($urandom % 30) == 0) max_val = W'($urandom);
         if (($urandom % 40) == 0) oneshot = ~oneshot;
         cycle();
      end
      start = 1'b0; stop = 1'b0; load = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
